// File: rtl/am2910_ucode_pipe_if.sv
`timescale 1ns/1ps
// Bus between the am2910 microcode pipeline and its surroundings: address, store
// loading and debug requests flow in, the issued microword fields flow out.
interface am2910_ucode_pipe_if #(
    parameter int AW     = 6,
    parameter int CTRL_W = 16,
    parameter int NFLAG  = 4
);
    logic [11:0]          Y;
    logic                 we;
    logic [AW-1:0]        waddr;
    logic [22+CTRL_W-1:0] wdata;
    logic [NFLAG-1:0]     status_in;
    logic                 flag_we;
    logic                 halt_req;
    logic                 run_req;
    logic                 step_req;
    logic [3:0]           I;
    logic                 CCEN_BAR;
    logic                 CC_BAR;
    logic                 RLD_BAR;
    logic                 CI;
    logic [11:0]          D;
    logic [CTRL_W-1:0]    ctrl;
    logic                 halted;

    modport master (
        output Y, we, waddr, wdata, status_in, flag_we, halt_req, run_req, step_req,
        input  I, CCEN_BAR, CC_BAR, RLD_BAR, CI, D, ctrl, halted
    );

    modport slave (
        input  Y, we, waddr, wdata, status_in, flag_we, halt_req, run_req, step_req,
        output I, CCEN_BAR, CC_BAR, RLD_BAR, CI, D, ctrl, halted
    );
endinterface

// File: rtl/am2910_ucode_pipe.sv
`timescale 1ns/1ps
// Control store + pipeline register behind an am2910 sequencer, with a flag mux for
// CC_BAR and a HALT/RUN/STEP controller that freezes the sequencer via a HOLD word.
module am2910_ucode_pipe #(
    parameter int AW     = 6,
    parameter int CTRL_W = 16,
    parameter int NFLAG  = 4
) (
    input  logic               clk,
    input  logic               rst,
    am2910_ucode_pipe_if.slave bus
);
    localparam int DEPTH = 2**AW;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [11:0]       d;
        logic              ci;
        logic              rld_bar;
        logic              ccpol;
        logic [1:0]        ccsel;
        logic              ccen_bar;
        logic [3:0]        i;
    } uword_t;

    typedef enum logic [1:0] {
        S_HALT = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2
    } state_t;

    // I=0 (JZ) so the first issued word after reset restarts the sequencer at 0.
    localparam uword_t RESET_W = uword_t'({{CTRL_W{1'b0}}, 12'd0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 4'd0});
    localparam uword_t NOP_W   = uword_t'({{CTRL_W{1'b0}}, 12'd0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 4'd14});
    // CONT with CI=0 recirculates uPC, so the sequencer stands still while halted.
    localparam uword_t HOLD_W  = uword_t'({{CTRL_W{1'b0}}, 12'd0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 4'd14});

    state_t           state_q, state_d;
    uword_t           pipe_q, pipe_d;
    logic [NFLAG-1:0] flags_q, flags_d;
    uword_t           store_q [DEPTH];

    uword_t           fetch_w;
    uword_t           issue_w;
    logic             y_oor;
    logic [3:0]       flags_ext;

    if (AW < 12) begin : g_oor
        assign y_oor = |bus.Y[11:AW];
    end else begin : g_no_oor
        assign y_oor = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HALT: begin
                if (bus.halt_req)      state_d = S_HALT;
                else if (bus.run_req)  state_d = S_RUN;
                else if (bus.step_req) state_d = S_STEP;
            end
            S_RUN: begin
                if (bus.halt_req) state_d = S_HALT;
            end
            S_STEP: begin
                if (bus.halt_req)     state_d = S_HALT;
                else if (bus.run_req) state_d = S_RUN;
                else                  state_d = S_HALT;
            end
            default: state_d = S_HALT;
        endcase
    end

    // The store is read asynchronously and captured at the edge, so a same-cycle
    // write to the fetched address is seen only on the following fetch.
    always_comb begin
        fetch_w = store_q[bus.Y[AW-1:0]];
        if (y_oor) fetch_w = NOP_W;
        pipe_d = pipe_q;
        if (state_q != S_HALT) pipe_d = fetch_w;
        flags_d = flags_q;
        if (bus.flag_we) flags_d = bus.status_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_HALT;
            pipe_q  <= RESET_W;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            pipe_q  <= pipe_d;
            flags_q <= flags_d;
        end
    end

    always_ff @(posedge clk) begin
        if (bus.we) store_q[bus.waddr] <= uword_t'(bus.wdata);
    end

    always_comb begin
        flags_ext = '0;
        flags_ext[NFLAG-1:0] = flags_q;
        issue_w = (state_q == S_HALT) ? HOLD_W : pipe_q;
    end

    assign bus.I        = issue_w.i;
    assign bus.CCEN_BAR = issue_w.ccen_bar;
    assign bus.RLD_BAR  = issue_w.rld_bar;
    assign bus.CI       = issue_w.ci;
    assign bus.D        = issue_w.d;
    assign bus.ctrl     = issue_w.ctrl;
    assign bus.CC_BAR   = ~(flags_ext[pipe_q.ccsel] ^ pipe_q.ccpol);
    assign bus.halted   = (state_q == S_HALT);
endmodule
